gate_sweep_ctrl: RTL

Exhaustive truth-table sequencer for one N-input single-output switch-level logic gate (NOR, NAND, etc.) instantiated alongside it by the parent.
Drives every input vector in ascending order and waits a settle interval per vector.
Samples the gate output, compares it against a built-in reference function, and reports a per-vector fail map, an error count and pass/done.
Sits in the gate-library characterisation bench and in the self-check wrapper of each gate cell.

---
 rtl/gate_sweep_pkg.sv | 44 ++++
 rtl/gate_sweep_ctrl_ref.sv | 18 +
 rtl/gate_sweep_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweep: function codes, FSM states
// and the reference evaluator for an N-input (N <= 4) reduction gate.
package gate_sweep_pkg;

  localparam logic [2:0] FN_NOR  = 3'd0;
  localparam logic [2:0] FN_NAND = 3'd1;
  localparam logic [2:0] FN_AND  = 3'd2;
  localparam logic [2:0] FN_OR   = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_XNOR = 3'd5;
  localparam logic [2:0] FN_LAST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Bits of vec at or above n are ignored, so callers may pass a zero-extended vector.
  function automatic logic ref_eval(input logic [2:0] func, input logic [3:0] vec,
                                    input int unsigned n);
    logic [3:0] mask;
    logic [3:0] bits;
    logic       all_ones;
    logic       any_one;
    logic       parity;
    mask     = 4'((32'd1 << n) - 32'd1);
    bits     = vec & mask;
    all_ones = (bits == mask);
    any_one  = |bits;
    parity   = ^bits;
    case (func)
      FN_NOR:  ref_eval = ~any_one;
      FN_NAND: ref_eval = ~all_ones;
      FN_AND:  ref_eval = all_ones;
      FN_OR:   ref_eval = any_one;
      FN_XOR:  ref_eval = parity;
      FN_XNOR: ref_eval = ~parity;
      default: ref_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_ref.sv
// Combinational reference model: expected output of the selected gate function
// for one input vector. Reusable by other gate benches.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      func_i,
  input  logic [N_IN-1:0] vec_i,
  output logic            exp_o
);

  logic [3:0] vec_ext;

  assign vec_ext = 4'(vec_i);
  assign exp_o   = ref_eval(func_i, vec_ext, N_IN);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sequencer for an N-input single-output gate.
// Define GATE_XZ_CHK_EN to count X/Z gate outputs as mismatches (simulation only).
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           func,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [(2**N_IN)-1:0] fail_vec
);

  localparam int              NV       = 2 ** N_IN;
  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [2:0]        func_q, func_d;
  logic [N_IN:0]     err_q, err_d;
  logic [NV-1:0]     fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              exp_bit;
  logic              mismatch;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .func_i (func_q),
    .vec_i  (vec_q),
    .exp_o  (exp_bit)
  );

`ifdef GATE_XZ_CHK_EN
  assign mismatch = (dut_out !== exp_bit);
`else
  // An unknown comparison result is not treated as a failure.
  assign mismatch = (dut_out != exp_bit);
`endif

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    func_d   = func_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d  = '0;
          fail_d = '0;
          pass_d = 1'b0;
          if (func <= FN_LAST) begin
            func_d   = func;
            vec_d    = '0;
            settle_d = '0;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_DONE;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == CNT_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          fail_d[vec_q] = 1'b1;
          err_d         = err_q + 1'b1;
        end
        if (vec_q == VEC_LAST) begin
          // err_d already includes this sample's outcome.
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = '0;
          state_d  = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      func_q   <= FN_NOR;
      err_q    <= '0;
      fail_q   <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      func_q   <= func_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in   = vec_q;
  assign busy     = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule
